demux_1to8_sipo: RTL and testbench

Serial-to-parallel receiver that reverses the 8-to-1 mux path. A bit stream produced by stepping a mux select 0..7 arrives on `D`, and a counter-driven 1-to-8 demultiplexer steers each bit into slot `Sel` of an 8-bit shadow register. After the eighth bit the block publishes the assembled byte on `Q` with a one-cycle `Done` pulse. It sits at the receiving end of the mux-based serial link, between the serial wire and byte-wide consumer logic.

---
 rtl/demux_1to8_sipo_pkg.sv | 14 +
 rtl/demux_1to8.sv | 21 ++
 rtl/demux_1to8_sipo.sv | 91 +++++++++
 tb/tb_demux_1to8_sipo.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/demux_1to8_sipo_pkg.sv
// Shared constants and state encoding for the 1-to-8 demux serial-to-parallel receiver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package demux_1to8_sipo_pkg;

    localparam int N     = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

endpackage : demux_1to8_sipo_pkg

// File: rtl/demux_1to8.sv
// Combinational 1-to-8 demultiplexer: steers D onto output Sel and raises that slot's write enable.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; En gates both outputs to zero.
module demux_1to8
    import demux_1to8_sipo_pkg::*;
(
    input  logic             D,
    input  logic [SEL_W-1:0] Sel,
    input  logic             En,
    output logic [N-1:0]     Y,
    output logic [N-1:0]     We
);

    // One-hot write enable at the selected slot; data output carries D on that slot only
    always_comb begin
        We      = '0;
        We[Sel] = En;
        Y       = We & {N{D}};
    end

endmodule : demux_1to8

// File: rtl/demux_1to8_sipo.sv
// Serial-to-parallel receiver: collects 8 LSB-first bits into a shadow byte and publishes it on Q with a Done pulse.
// Latency: Q/Done update on the edge sampling the 8th bit; visible the following cycle. Y is combinational.
// Backpressure: none; En=0 simply stalls collection (no timeout), Start always restarts the frame.
module demux_1to8_sipo
    import demux_1to8_sipo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             En,
    input  logic             D,
    output logic [SEL_W-1:0] Sel,
    output logic [N-1:0]     Y,
    output logic [N-1:0]     Q,
    output logic             Done,
    output logic             Busy
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N-1:0]     shadow_q, shadow_d;
    logic [N-1:0]     q_q, q_d;
    logic             done_q, done_d;

    logic             collecting;
    logic             complete;
    logic [N-1:0]     slot_we;

    assign collecting = (state_q == ST_COLLECT);
    // Last slot sampled this edge; completion holds even if Start arrives on the same edge
    assign complete   = collecting && En && (sel_q == SEL_W'(N-1));

    demux_1to8 u_demux (
        .D   (D),
        .Sel (sel_q),
        .En  (En && collecting),
        .Y   (Y),
        .We  (slot_we)
    );

    // Next-state, slot counter, shadow and output byte; Start takes priority over a normal bit write
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        q_d      = q_q;
        done_d   = 1'b0;

        if (complete) begin
            q_d    = {D, shadow_q[N-2:0]};
            done_d = 1'b1;
        end

        if (Start) begin
            // Fresh frame; a coincident En bit lands in slot 0
            state_d     = ST_COLLECT;
            shadow_d    = '0;
            shadow_d[0] = En & D;
            sel_d       = En ? SEL_W'(1) : '0;
        end else if (collecting && En) begin
            shadow_d = (shadow_q & ~slot_we) | Y;
            sel_d    = sel_q + SEL_W'(1);
            if (complete) begin
                state_d = ST_IDLE;
            end
        end
    end

    // State registers with asynchronous reset that discards any partial frame and clears Q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            shadow_q <= '0;
            q_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            q_q      <= q_d;
            done_q   <= done_d;
        end
    end

    assign Sel  = sel_q;
    assign Q    = q_q;
    assign Done = done_q;
    assign Busy = collecting;

endmodule : demux_1to8_sipo

// File: tb/tb_demux_1to8_sipo.sv
module tb_demux_1to8_sipo;

    logic       clk = 1'b0;
    logic       rst;
    logic       Start, En, D;
    logic [2:0] Sel;
    logic [7:0] Y, Q;
    logic       Done, Busy;

    int n_checks = 0;
    int n_fail   = 0;
    int dcount   = 0;

    // Reference model: a frame is an ordered list of received bits
    bit         m_active;
    bit         m_bits[$];
    logic [7:0] m_q;
    bit         m_done;

    always #5 clk = ~clk;

    demux_1to8_sipo dut (
        .clk   (clk),
        .rst   (rst),
        .Start (Start),
        .En    (En),
        .D     (D),
        .Sel   (Sel),
        .Y     (Y),
        .Q     (Q),
        .Done  (Done),
        .Busy  (Busy)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] pack_bits();
        logic [7:0] v = '0;
        for (int k = 0; k < m_bits.size(); k++) v = v + (8'(m_bits[k]) << k);
        return v;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_bits.delete();
        m_q    = 8'h00;
        m_done = 0;
    endtask

    // One clock cycle: drive, check Y combinationally, step model, check registered outputs
    task automatic cyc(input logic s, input logic e, input logic dd);
        logic [7:0] exp_y;
        @(negedge clk);
        Start = s; En = e; D = dd;
        #1;
        exp_y = (m_active && e && dd) ? 8'(8'd1 << m_bits.size()) : 8'h00;
        check("Y", Y, exp_y);

        m_done = 0;
        if (s) begin
            if (m_active && e && m_bits.size() == 7) begin
                m_bits.push_back(dd);
                m_q    = pack_bits();
                m_done = 1;
            end
            m_bits.delete();
            if (e) m_bits.push_back(dd);
            m_active = 1;
        end else if (m_active && e) begin
            m_bits.push_back(dd);
            if (m_bits.size() == 8) begin
                m_q    = pack_bits();
                m_done = 1;
                m_bits.delete();
                m_active = 0;
            end
        end

        @(posedge clk);
        #1;
        check("Sel",  8'(Sel),  8'(m_bits.size()));
        check("Q",    Q,        m_q);
        check("Done", 8'(Done), 8'(m_done));
        check("Busy", 8'(Busy), 8'(m_active));
        if (Done) dcount++;
    endtask

    // Start cycle (no En) followed by 8 bits; optional 3-cycle En gap after slot 3
    task automatic send_byte(input logic [7:0] b, input bit gap);
        cyc(1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, b[i]);
            if (gap && i == 3) begin
                for (int g = 0; g < 3; g++) begin
                    cyc(0, 0, 1'($urandom_range(0, 1)));
                    check("gap_sel", 8'(Sel), 8'd4);
                end
            end
        end
    endtask

    // Asynchronous reset between edges, checked before the next edge
    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_Q",    Q,        8'h00);
        check("rst_Sel",  8'(Sel),  8'h00);
        check("rst_Busy", 8'(Busy), 8'h00);
        check("rst_Done", 8'(Done), 8'h00);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        Start = 0; En = 0; D = 0; rst = 0;
        model_reset();
        async_reset();

        // Idle traffic is ignored
        dcount = 0;
        for (int i = 0; i < 10; i++) cyc(0, 1, 1);
        check("idle_Q", Q, 8'h00);
        check("idle_done_cnt", 8'(dcount), 8'd0);

        // Full frame
        dcount = 0;
        send_byte(8'h85, 0);
        check("full_Q", Q, 8'h85);
        check("full_done_cnt", 8'(dcount), 8'd1);
        check("full_Sel", 8'(Sel), 8'd0);

        // Gapped frame
        dcount = 0;
        send_byte(8'h85, 1);
        check("gap_Q", Q, 8'h85);
        check("gap_done_cnt", 8'(dcount), 8'd1);

        // Abort after 5 bits, then 8'h3C
        dcount = 0;
        cyc(1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1);
        send_byte(8'h3C, 0);
        check("abort_Q", Q, 8'h3C);
        check("abort_done_cnt", 8'(dcount), 8'd1);

        // Back-to-back: Start+En on the completion edge. That single D bit (A5 bit 7 = 1)
        // is also slot 0 of the next frame, so bits 1..7 of 5A yield {5A[7:1],1} = 8'h5B.
        dcount = 0;
        begin
            logic [7:0] a = 8'hA5;
            logic [7:0] b = 8'h5A;
            cyc(1, 0, 0);
            for (int i = 0; i < 7; i++) cyc(0, 1, a[i]);
            cyc(1, 1, a[7]);
            check("b2b_Q1", Q, 8'hA5);
            check("b2b_Busy", 8'(Busy), 8'd1);
            check("b2b_Sel", 8'(Sel), 8'd1);
            for (int i = 1; i < 8; i++) cyc(0, 1, b[i]);
            check("b2b_Q2", Q, 8'h5B);
            check("b2b_done_cnt", 8'(dcount), 8'd2);
        end

        // Async reset after 4 bits, then a full 8'hFF frame
        cyc(1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1);
        async_reset();
        send_byte(8'hFF, 0);
        check("post_rst_Q", Q, 8'hFF);

        // Minimum 8-cycle frame with Start+En in IDLE
        begin
            logic [7:0] c = 8'hC3;
            cyc(1, 1, c[0]);
            for (int i = 1; i < 8; i++) cyc(0, 1, c[i]);
            check("min_Q", Q, 8'hC3);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset();
            cyc(1'($urandom_range(0, 11) == 0),
                1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_demux_1to8_sipo
